red_pitaya_pll_ctrl: RTL and testbench

RED_PITAYA_PLL_CTRL -- requirements
Module: red_pitaya_pll_ctrl

---
 rtl/red_pitaya_pll_ctrl_if.sv | 34 +++
 rtl/red_pitaya_pll_ctrl.sv | 171 +++++++++++++++++
 tb/tb_red_pitaya_pll_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_pll_ctrl_if.sv
// Signal bundle between the PLL sequencing controller and the PLL / system side.
// master = controller, slave = PLL and the logic it feeds.
interface red_pitaya_pll_ctrl_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rstn;
  logic [2:0] state_o;
  logic [7:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic       fault;

  modport master (
    input  pll_locked,
    input  restart,
    output pll_rst,
    output sys_rstn,
    output state_o,
    output retry_cnt,
    output lost_cnt,
    output fault
  );

  modport slave (
    output pll_locked,
    output restart,
    input  pll_rst,
    input  sys_rstn,
    input  state_o,
    input  retry_cnt,
    input  lost_cnt,
    input  fault
  );
endinterface

// File: rtl/red_pitaya_pll_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream reset; retries on timeout and latches FAULT after too many.
//
// state      | meaning
// RESET      | pll_rst held high for RST_CYC cycles
// WAIT_LOCK  | waiting up to TMO_CYC cycles for synchronized lock
// STABLE     | lock must stay high for LOCK_CYC consecutive cycles
// RUN        | sys_rstn released, watching for lock loss
// FAULT      | MAX_RETRY consecutive failed attempts, waits for restart
module red_pitaya_pll_ctrl #(
  parameter int RST_CYC   = 16,
  parameter int LOCK_CYC  = 1024,
  parameter int TMO_CYC   = 65536,
  parameter int MAX_RETRY = 8
) (
  input logic                   clk,
  input logic                   rstn,
  red_pitaya_pll_ctrl_if.master bus
);

  localparam int CNT_MAX = (RST_CYC > LOCK_CYC)
                           ? ((RST_CYC  > TMO_CYC) ? RST_CYC  : TMO_CYC)
                           : ((LOCK_CYC > TMO_CYC) ? LOCK_CYC : TMO_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [7:0]    RETRY_LIM = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    retry_q;
  logic [7:0]    retry_d;
  logic [7:0]    lost_q;
  logic          pll_rst_q;
  logic          sys_rstn_q;
  logic          fault_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          lock_s;

  // pll_locked is asynchronous to clk; nothing else may look at it directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s  = sync2_q;
  assign retry_d = retry_q + 8'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      retry_q    <= 8'd0;
      lost_q     <= 8'd0;
      pll_rst_q  <= 1'b1;
      sys_rstn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else if (bus.restart) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      retry_q    <= 8'd0;
      pll_rst_q  <= 1'b1;
      sys_rstn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            // The sample that ends the wait is the first of the consecutive highs.
            if (LOCK_CYC == 1) begin
              state_q    <= ST_RUN;
              cnt_q      <= '0;
              retry_q    <= 8'd0;
              sys_rstn_q <= 1'b1;
            end else begin
              state_q <= ST_STABLE;
              cnt_q   <= CNT_ONE;
            end
          end else if (cnt_q == TMO_LAST) begin
            cnt_q     <= '0;
            retry_q   <= retry_d;
            pll_rst_q <= 1'b1;
            if (retry_d == RETRY_LIM) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_RESET;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_STABLE: begin
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            retry_q    <= 8'd0;
            sys_rstn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            pll_rst_q  <= 1'b1;
            sys_rstn_q <= 1'b0;
            if (lost_q != 8'hFF) begin
              lost_q <= lost_q + 8'd1;
            end
          end
        end

        ST_FAULT: begin
          pll_rst_q  <= 1'b1;
          sys_rstn_q <= 1'b0;
          fault_q    <= 1'b1;
        end

        default: begin
          state_q    <= ST_RESET;
          cnt_q      <= '0;
          pll_rst_q  <= 1'b1;
          sys_rstn_q <= 1'b0;
          fault_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_o   = state_q;
  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rstn  = sys_rstn_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.lost_cnt  = lost_q;

endmodule

// File: tb/tb_red_pitaya_pll_ctrl.sv
// Bench for red_pitaya_pll_ctrl: directed scenarios plus a randomized lock pattern,
// every cycle compared against a reference model built from the sequencing rules.
`timescale 1ns/1ps
module tb_red_pitaya_pll_ctrl;
  localparam int RST_CYC   = 4;
  localparam int LOCK_CYC  = 8;
  localparam int TMO_CYC   = 32;
  localparam int MAX_RETRY = 3;
  localparam logic [21:0] RST_VALS = {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};

  logic clk = 1'b0;
  logic rstn;
  red_pitaya_pll_ctrl_if bus ();

  always #5 clk = ~clk;

  red_pitaya_pll_ctrl #(
    .RST_CYC  (RST_CYC),
    .LOCK_CYC (LOCK_CYC),
    .TMO_CYC  (TMO_CYC),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  int run_left;

  // Reference model: state code, edges spent in state, consecutive highs, counters,
  // and the two-sample delay of the lock synchronizer as a queue.
  int   m_st, m_age, m_highs, m_retry, m_lost;
  logic m_q[$];

  task automatic model_go(input int s);
    m_st  = s;
    m_age = 0;
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_highs = 0; m_retry = 0; m_lost = 0;
    m_q.delete();
    m_q.push_back(1'b0);
    m_q.push_back(1'b0);
  endtask

  task automatic model_step();
    logic ls;
    if (!rstn) begin
      model_reset();
      return;
    end
    ls = m_q.pop_front();
    m_q.push_back(bus.pll_locked);
    if (bus.restart) begin
      m_retry = 0;
      model_go(0);
      return;
    end
    case (m_st)
      0: begin
        m_age++;
        if (m_age == RST_CYC) model_go(1);
      end
      1: begin
        m_age++;
        if (ls) begin
          m_highs = 1;
          if (m_highs >= LOCK_CYC) begin m_retry = 0; model_go(3); end
          else model_go(2);
        end else if (m_age == TMO_CYC) begin
          m_retry++;
          model_go((m_retry == MAX_RETRY) ? 4 : 0);
        end
      end
      2: begin
        if (!ls) model_go(1);
        else begin
          m_highs++;
          if (m_highs == LOCK_CYC) begin m_retry = 0; model_go(3); end
        end
      end
      3: begin
        if (!ls) begin
          if (m_lost < 255) m_lost++;
          model_go(0);
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [21:0] model_exp();
    return {3'(m_st), (m_st == 0 || m_st == 4), (m_st == 3), (m_st == 4),
            8'(m_retry), 8'(m_lost)};
  endfunction

  function automatic logic [21:0] dut_obs();
    return {bus.state_o, bus.pll_rst, bus.sys_rstn, bus.fault, bus.retry_cnt, bus.lost_cnt};
  endfunction

  task automatic check_vec(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_vec(tag, dut_obs(), model_exp());
  endtask

  initial begin
    rstn = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart = 1'b0;
    model_reset();
    repeat (3) tick("in_reset");
    check_vec("reset_values", dut_obs(), RST_VALS);

    // Nominal bring-up
    rstn = 1'b1;
    n = 0;
    while (bus.pll_rst && n < 20) begin tick("nominal"); n++; end
    check_int("pll_rst_len", n, RST_CYC);
    repeat (6) tick("nominal");
    bus.pll_locked = 1'b1;
    n = 0;
    while (!bus.sys_rstn && n < 60) begin tick("nominal_lock"); n++; end
    check_int("lock_to_run", n, 2 + LOCK_CYC);
    check_int("retry_nominal", int'(bus.retry_cnt), 0);
    repeat (5) tick("run");

    // Lock lost in RUN for 3 cycles
    bus.pll_locked = 1'b0;
    n = 0;
    while (bus.sys_rstn && n < 10) begin tick("loss"); n++; end
    check_int("loss_to_sysrst", n, 3);
    bus.pll_locked = 1'b1;
    check_int("lost_after_loss", int'(bus.lost_cnt), 1);
    check_int("pll_rst_on_loss", int'(bus.pll_rst), 1);
    n = 0;
    while (!bus.sys_rstn && n < 100) begin tick("relock"); n++; end
    check_int("relock_cycles", n, 12);
    repeat (3) tick("run2");

    // Restart in RUN
    bus.restart = 1'b1;
    tick("restart_run");
    bus.restart = 1'b0;
    check_int("restart_run_state", int'(bus.state_o), 0);
    check_int("restart_run_lost", int'(bus.lost_cnt), 1);
    check_int("restart_run_sysrst", int'(bus.sys_rstn), 0);

    // Glitchy lock: 5 high, 1 low, then steady
    bus.pll_locked = 1'b0;
    repeat (8) tick("glitch_pre");
    bus.pll_locked = 1'b1;
    repeat (5) tick("glitch_hi");
    bus.pll_locked = 1'b0;
    tick("glitch_lo");
    bus.pll_locked = 1'b1;
    n = 0;
    while (!bus.sys_rstn && n < 60) begin tick("glitch_steady"); n++; end
    check_int("glitch_to_run", n, 2 + LOCK_CYC);
    check_int("glitch_retry", int'(bus.retry_cnt), 0);
    repeat (3) tick("run3");

    // Never relocks: three attempts then FAULT
    bus.pll_locked = 1'b0;
    n = 0;
    while (!bus.fault && n < 200) begin tick("no_lock"); n++; end
    check_int("fault_cycles", n, 3 + 3 * (RST_CYC + TMO_CYC));
    check_int("fault_state", int'(bus.state_o), 4);
    check_int("fault_retry", int'(bus.retry_cnt), MAX_RETRY);
    check_int("fault_pll_rst", int'(bus.pll_rst), 1);
    check_int("fault_lost", int'(bus.lost_cnt), 2);
    repeat (10) tick("fault_hold");

    // Restart in FAULT
    bus.restart = 1'b1;
    tick("restart_fault");
    bus.restart = 1'b0;
    check_int("restart_fault_state", int'(bus.state_o), 0);
    check_int("restart_fault_retry", int'(bus.retry_cnt), 0);
    check_int("restart_fault_flag", int'(bus.fault), 0);
    check_int("restart_fault_lost", int'(bus.lost_cnt), 2);

    // Randomized lock runs with occasional restarts
    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        bus.pll_locked = ~bus.pll_locked;
        run_left = bus.pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
      end
      run_left--;
      bus.restart = ($urandom_range(0, 127) == 0);
      tick("random");
    end
    bus.restart = 1'b0;

    // Async reset pulse in the middle of RUN
    bus.pll_locked = 1'b1;
    bus.restart = 1'b1;
    tick("pre_async");
    bus.restart = 1'b0;
    n = 0;
    while (!bus.sys_rstn && n < 60) begin tick("pre_async_lock"); n++; end
    check_int("pre_async_run", int'(bus.state_o), 3);
    repeat (3) tick("pre_async_run");
    #2 rstn = 1'b0;
    #0.5 check_vec("async_rst_asserted", dut_obs(), RST_VALS);
    #0.5 rstn = 1'b1;
    #1 check_vec("async_rst_released", dut_obs(), RST_VALS);
    model_reset();
    repeat (20) tick("after_async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
